// File: rtl/sram_chip_responder.sv
// Cycle-based device model of a 256K x 16 async SRAM: byte-lane writes, pipelined reads, access counters.
// Optional contention checker and first-error cycle capture are enabled by SRAM_RESP_CONTENTION_CHECK_EN.
module sram_chip_responder #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 262144,
  parameter int READ_LAT  = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_OE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count,
  output logic              proto_err
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int STG   = (READ_LAT < 1) ? 1 : READ_LAT;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              rd_en, wr, rd, x_err, cont_evt;
  logic [STG:1]      vld_q, vld_d, ub_q, ub_d, lb_q, lb_d;
  logic [STG:1][DATA_W-1:0] dat_q, dat_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d, rd_count_q, rd_count_d;
  logic              proto_err_q, proto_err_d;
  logic [DATA_W-1:0] dout;
  logic              drv_hi, drv_lo;

  assign idx   = SRAM_ADDR[IDX_W-1:0];
  assign rd_en = ~SRAM_CE_N & SRAM_WE_N & ~SRAM_OE_N;
  assign wr    = rst & ~SRAM_CE_N & ~SRAM_WE_N;
  assign rd    = rst & rd_en;

  always_comb begin
    x_err = 1'b0;
`ifndef SYNTHESIS
    if (!SRAM_CE_N && ($isunknown(SRAM_ADDR) || $isunknown(SRAM_WE_N) || $isunknown(SRAM_OE_N)))
      x_err = 1'b1;
`endif
  end

  // Stage 1 captures the word as stored before this edge's write, so in-flight data never sees later writes.
  always_comb begin
    vld_d = '0;
    ub_d  = '0;
    lb_d  = '0;
    dat_d = dat_q;
    if (READ_LAT > 0) begin
      vld_d[1] = rd;
      ub_d[1]  = ~SRAM_UB_N;
      lb_d[1]  = ~SRAM_LB_N;
      dat_d[1] = mem[idx];
      for (int i = 2; i <= STG; i++) begin
        vld_d[i] = vld_q[i-1];
        ub_d[i]  = ub_q[i-1];
        lb_d[i]  = lb_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  always_comb begin
    if (READ_LAT == 0) begin
      dout   = mem[idx];
      drv_hi = rd_en & ~SRAM_UB_N;
      drv_lo = rd_en & ~SRAM_LB_N;
    end else begin
      dout   = dat_q[STG];
      drv_hi = vld_q[STG] & ub_q[STG];
      drv_lo = vld_q[STG] & lb_q[STG];
    end
  end

  assign SRAM_DQ[DATA_W-1:8] = drv_hi ? dout[DATA_W-1:8] : 8'bz;
  assign SRAM_DQ[7:0]        = drv_lo ? dout[7:0]        : 8'bz;

  always_comb begin
    wr_count_d  = wr_count_q + CNT_W'(wr);
    rd_count_d  = rd_count_q + CNT_W'(rd);
    proto_err_d = proto_err_q | (wr & |vld_q) | x_err | cont_evt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q       <= '0;
      ub_q        <= '0;
      lb_q        <= '0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      ub_q        <= ub_d;
      lb_q        <= lb_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
      proto_err_q <= proto_err_d;
    end
    dat_q <= dat_d;
  end

  // Storage is deliberately not reset so contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      if (!SRAM_LB_N) mem[idx][7:0]        <= SRAM_DQ[7:0];
      if (!SRAM_UB_N) mem[idx][DATA_W-1:8] <= SRAM_DQ[DATA_W-1:8];
    end
  end

`ifdef SRAM_RESP_CONTENTION_CHECK_EN
  logic [CNT_W-1:0] cyc_q, cyc_d, first_err_cycle_q, first_err_cycle_d;
  logic             first_seen_q, first_seen_d, err_now;

  always_comb begin
    cont_evt          = ~SRAM_WE_N & (drv_hi | drv_lo);
    err_now           = rst & ((wr & |vld_q) | x_err | cont_evt);
    cyc_d             = cyc_q + CNT_W'(1);
    first_seen_d      = first_seen_q | err_now;
    first_err_cycle_d = (err_now & ~first_seen_q) ? cyc_q : first_err_cycle_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_q             <= '0;
      first_seen_q      <= 1'b0;
      first_err_cycle_q <= '0;
    end else begin
      cyc_q             <= cyc_d;
      first_seen_q      <= first_seen_d;
      first_err_cycle_q <= first_err_cycle_d;
    end
  end

  assign proto_err = proto_err_q | cont_evt;
`else
  assign cont_evt  = 1'b0;
  assign proto_err = proto_err_q;
`endif

  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;
endmodule

// File: tb/tb_sram_chip_responder.sv
// Directed bench: dut_a uses defaults (READ_LAT=1), dut_b uses READ_LAT=2 with a 1024-word aliased array.
// Bus pulldowns make an undriven byte lane read as 0x00, so high-Z is checked against nonzero stored data.
module tb_sram_chip_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] a_addr, b_addr;
  logic a_we_n, a_oe_n, a_ce_n, a_ub_n, a_lb_n, a_den;
  logic b_we_n, b_oe_n, b_ce_n, b_ub_n, b_lb_n, b_den;
  logic [15:0] a_drv, b_drv;
  logic [15:0] a_wc, a_rc, b_wc, b_rc;
  logic a_err, b_err;
  wire  [15:0] a_dq, b_dq;

  assign a_dq = a_den ? a_drv : 16'hzzzz;
  assign b_dq = b_den ? b_drv : 16'hzzzz;
  pulldown pd_a (a_dq);
  pulldown pd_b (b_dq);

  sram_chip_responder dut_a (
    .clk(clk), .rst(rst), .SRAM_ADDR(a_addr), .SRAM_DQ(a_dq),
    .SRAM_WE_N(a_we_n), .SRAM_OE_N(a_oe_n), .SRAM_CE_N(a_ce_n),
    .SRAM_UB_N(a_ub_n), .SRAM_LB_N(a_lb_n),
    .wr_count(a_wc), .rd_count(a_rc), .proto_err(a_err));

  sram_chip_responder #(.READ_LAT(2), .MEM_DEPTH(1024)) dut_b (
    .clk(clk), .rst(rst), .SRAM_ADDR(b_addr), .SRAM_DQ(b_dq),
    .SRAM_WE_N(b_we_n), .SRAM_OE_N(b_oe_n), .SRAM_CE_N(b_ce_n),
    .SRAM_UB_N(b_ub_n), .SRAM_LB_N(b_lb_n),
    .wr_count(b_wc), .rd_count(b_rc), .proto_err(b_err));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input bit b, input logic [17:0] ad, input logic ce, input logic we,
                     input logic oe, input logic ub, input logic lb, input logic [15:0] d);
    if (!b) begin
      a_addr = ad; a_ce_n = ce; a_we_n = we; a_oe_n = oe; a_ub_n = ub; a_lb_n = lb;
      a_drv = d; a_den = ~we;
    end else begin
      b_addr = ad; b_ce_n = ce; b_we_n = we; b_oe_n = oe; b_ub_n = ub; b_lb_n = lb;
      b_drv = d; b_den = ~we;
    end
  endtask

  task automatic wr(input bit b, input logic [17:0] ad, input logic [15:0] d,
                    input logic ub, input logic lb);
    bus(b, ad, 1'b0, 1'b0, 1'b1, ub, lb, d);
  endtask

  task automatic rd(input bit b, input logic [17:0] ad, input logic ub, input logic lb);
    bus(b, ad, 1'b0, 1'b1, 1'b0, ub, lb, 16'h0000);
  endtask

  task automatic idle(input bit b);
    bus(b, 18'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
  endtask

  initial begin
    idle(0); idle(1);
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    chk("rst_a_wc", a_wc, 16'd0);
    chk("rst_a_rc", a_rc, 16'd0);
    chk("rst_a_err", {15'b0, a_err}, 16'd0);
    chk("rst_b_wc", b_wc, 16'd0);
    chk("rst_a_dq_z", a_dq, 16'h0000);
    chk("rst_b_dq_z", b_dq, 16'h0000);

    // Basic write/read plus read-after-write in consecutive cycles
    wr(0, 18'd5, 16'h1234, 1'b0, 1'b0); step();
    rd(0, 18'd5, 1'b0, 1'b0); step();
    chk("t1_dq", a_dq, 16'h1234);
    chk("t1_wc", a_wc, 16'd1);
    chk("t1_rc", a_rc, 16'd1);
    idle(0); step();
    chk("t1_dq_release", a_dq, 16'h0000);

    // Byte lanes
    wr(0, 18'd9, 16'hFFFF, 1'b0, 1'b0); step();
    wr(0, 18'd9, 16'hAB00, 1'b0, 1'b1); step();
    rd(0, 18'd9, 1'b0, 1'b0); step();
    chk("t2_ub_merge", a_dq, 16'hABFF);
    rd(0, 18'd9, 1'b0, 1'b1); step();
    chk("t2_lb_z", a_dq, 16'hAB00);
    idle(0); step();

    // 32-bit store split into two halves
    wr(0, 18'd1, 16'hBEEF, 1'b0, 1'b0); step();
    wr(0, 18'd0, 16'hDEAD, 1'b0, 1'b0); step();
    rd(0, 18'd1, 1'b0, 1'b0); step();
    chk("t3_lo", a_dq, 16'hBEEF);
    rd(0, 18'd0, 1'b0, 1'b0); step();
    chk("t3_hi", a_dq, 16'hDEAD);
    idle(0); step();
    chk("t3_err", {15'b0, a_err}, 16'd0);
    chk("t3_wc", a_wc, 16'd5);
    chk("t3_rc", a_rc, 16'd5);

    // WE_N and OE_N both low is a write, not a read
    bus(0, 18'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0F0F); step();
    chk("weoe_rc", a_rc, 16'd5);
    chk("weoe_wc", a_wc, 16'd6);
    rd(0, 18'd2, 1'b0, 1'b0); step();
    chk("weoe_dq", a_dq, 16'h0F0F);
    idle(0); step();
    // Write with both lanes off is counted but changes nothing
    wr(0, 18'd2, 16'hFFFF, 1'b1, 1'b1); step();
    rd(0, 18'd2, 1'b0, 1'b0); step();
    chk("nolane_dq", a_dq, 16'h0F0F);
    idle(0); step();
    chk("nolane_wc", a_wc, 16'd7);
    // CE_N high: no write, no read sample
    bus(0, 18'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1111); step();
    bus(0, 18'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); step();
    chk("ce_off_dq", a_dq, 16'h0000);
    rd(0, 18'd2, 1'b0, 1'b0); step();
    chk("ce_off_data", a_dq, 16'h0F0F);
    chk("ce_off_wc", a_wc, 16'd7);
    chk("ce_off_rc", a_rc, 16'd8);
    idle(0); step();

    // READ_LAT=2 with address aliasing
    wr(1, 18'h000, 16'h5A5A, 1'b0, 1'b0); step();
    rd(1, 18'h400, 1'b0, 1'b0); step();
    chk("t4_gap_z", b_dq, 16'h0000);
    idle(1); step();
    chk("t4_alias", b_dq, 16'h5A5A);
    step();
    chk("t4_release", b_dq, 16'h0000);

    // Write while a read is in flight: old data returned, sticky error
    wr(1, 18'd7, 16'h7777, 1'b0, 1'b0); step();
    rd(1, 18'd7, 1'b0, 1'b0); step();
    wr(1, 18'd7, 16'h1111, 1'b0, 1'b0); step();
    idle(1); #1;
    chk("t6_old_data", b_dq, 16'h7777);
    chk("t6_err", {15'b0, b_err}, 16'd1);
    step(); step();
    chk("t6_err_held", {15'b0, b_err}, 16'd1);
    chk("t6_b_wc", b_wc, 16'd3);
    chk("t6_b_rc", b_rc, 16'd2);
    chk("t6_a_err", {15'b0, a_err}, 16'd0);

    // Reset during an in-flight read; memory survives
    wr(0, 18'd3, 16'hC3C3, 1'b0, 1'b0); step();
    rd(0, 18'd3, 1'b0, 1'b0); step();
    chk("t5_pre", a_dq, 16'hC3C3);
    rst = 1'b0; step();
    chk("t5_dq_z", a_dq, 16'h0000);
    chk("t5_wc", a_wc, 16'd0);
    chk("t5_rc", a_rc, 16'd0);
    chk("t5_b_err", {15'b0, b_err}, 16'd0);
    rst = 1'b1;
    rd(0, 18'd3, 1'b0, 1'b0); step();
    chk("t5_retained", a_dq, 16'hC3C3);
    chk("t5_rc_after", a_rc, 16'd1);
    idle(0); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_chip_responder.md
Name: sram_chip_responder

Overview:
- Synthesizable, cycle-based model of the external 256K x 16 asynchronous SRAM: the device side of the SRAM pin interface driven by the SRAM controller.
- Stores words, honours byte-lane enables, and drives SRAM_DQ back on reads after a configurable latency.
- Used in controller and memory-stage testbenches and on the FPGA when the board SRAM is unavailable.
- Also exposes access counters and a sticky protocol-error flag for checking.

Parameters:
- ADDR_W, 18, SRAM_ADDR width.
- DATA_W, 16, SRAM_DQ width; must be 16 because the lanes are fixed at 2 x 8 bits.
- MEM_DEPTH, 262144, number of stored words; the index is SRAM_ADDR mod MEM_DEPTH, and MEM_DEPTH must be a power of two.
- READ_LAT, 1, cycles from read sample to DQ drive; legal values 0..3; 0 = combinational read.
- CNT_W, 16, width of the access counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low: state is reset when rst=0 at a rising clk edge.
- SRAM_ADDR  input  ADDR_W  word address.
- SRAM_DQ  inout  DATA_W  bidirectional data; driven only during reads, otherwise high-Z.
- SRAM_WE_N  input  1  write enable, active-low.
- SRAM_OE_N  input  1  output enable, active-low.
- SRAM_CE_N  input  1  chip enable, active-low.
- SRAM_UB_N  input  1  upper byte lane [15:8] enable, active-low.
- SRAM_LB_N  input  1  lower byte lane [7:0] enable, active-low.
- wr_count  output  CNT_W  number of accepted write cycles.
- rd_count  output  CNT_W  number of accepted read samples.
- proto_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=0 at an edge):
  - read pipeline valid bits cleared, so SRAM_DQ is high-Z from the next cycle;
  - wr_count=0, rd_count=0, proto_err=0;
  - memory contents retained;
  - any access present in that cycle is ignored and not counted.
- Write (edge with rst=1, CE_N=0, WE_N=0):
  - mem[idx][7:0] <= DQ[7:0] if LB_N=0; mem[idx][15:8] <= DQ[15:8] if UB_N=0;
  - wr_count increments, wrapping modulo 2^CNT_W;
  - WE_N=0 takes priority over OE_N: OE_N=0 together with WE_N=0 is still a write, and the device never drives DQ in that cycle;
  - UB_N=LB_N=1 with WE_N=0 is a counted write that changes no memory.
- Read sample (edge with rst=1, CE_N=0, WE_N=1, OE_N=0):
  - when READ_LAT>=1, the pipeline stage 1 captures {valid=1, data=mem[idx], ub=~UB_N, lb=~LB_N};
  - rd_count increments;
  - stages shift each cycle, and stage READ_LAT drives DQ. A read sampled at edge k drives DQ from edge k+READ_LAT-1 through edge k+READ_LAT, i.e. for one full cycle;
  - the default READ_LAT=1 means the address presented in cycle N returns data in cycle N+1, which matches the controller's ADDR/READ state pairs.
- READ_LAT=0:
  - DQ = mem[idx] combinationally whenever CE_N=0, OE_N=0 and WE_N=1;
  - rd_count increments once per cycle in that condition.
- Lane drive: each byte lane is driven only if its enable was captured asserted; a disabled lane is high-Z.
- Data hazards:
  - Read-after-write to the same address in consecutive cycles returns the new data.
  - Data already in the pipeline is not updated by a later write (old data is returned).
- Idle: with CE_N=1, nothing is written, sampled or counted, and stage 1 captures valid=0.
- Reset mid-read: the pipeline is flushed and DQ goes high-Z one cycle later, even if a read was in flight.
- proto_err is set when any of the following occurs, and is held until reset:
  - a write edge occurs while any pipeline stage is valid;
  - SRAM_ADDR, SRAM_WE_N or SRAM_OE_N contain X or Z while CE_N=0 (simulation only, guarded by the synthesis translate directives).

Optional Feature:
- Macro SRAM_RESP_CONTENTION_CHECK_EN.
- Defined: extra check logic records the cycle number of the first contention in a debug register `first_err_cycle`, a CNT_W-bit free-running cycle counter cleared by reset. It also asserts proto_err one cycle earlier, combinationally, whenever WE_N=0 and the DQ output enable are both active in the same cycle.
- Not defined: no cycle counter or debug register; proto_err is registered only, as specified in Behaviour.

Test Plan:
- Write 0x1234 to addr 5 (UB_N=LB_N=0), then read addr 5 with READ_LAT=1 -> DQ=0x1234 in the following cycle; wr_count=1, rd_count=1.
- Write 0xFFFF to addr 9, then write 0xAB00 with UB_N=0, LB_N=1 -> read of addr 9 returns 0xABFF; a read with LB_N=1 shows DQ[7:0] high-Z.
- Controller-style 32-bit store: data_in 0xDEADBEEF, low half to addr 0x00001, high half to addr 0x00000 -> subsequent reads return 0xBEEF and 0xDEAD; no proto_err.
- READ_LAT=2 and MEM_DEPTH=1024: write 0x5A5A to addr 0x000, read addr 0x400 -> 0x5A5A appears 2 cycles after the sample (aliasing); DQ high-Z in the intervening cycle.
- Read addr 3, then drive rst=0 at the next edge -> DQ high-Z in the following cycle; counters 0; a read of addr 3 after reset returns pre-reset contents.
- Read sampled, then WE_N=0 in the next cycle with READ_LAT=2 -> proto_err=1 and held; with SRAM_RESP_CONTENTION_CHECK_EN, first_err_cycle equals that cycle's count.
